// File: rtl/sign_extension_arbiter.sv
// Two-requester round-robin arbiter feeding one shared sign-extension path into a registered output.
// Optional per-requester grant counters are enabled with `define SIGN_EXT_ARB_COUNT_EN.
module sign_extension_arbiter #(
    parameter int unsigned WIDTH_OF_INPUT_DATA  = 8,
    parameter int unsigned WIDTH_OF_OUTPUT_DATA = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req0_valid,
    input  logic [WIDTH_OF_INPUT_DATA-1:0]  req0_data,
    output logic                            req0_ready,
    input  logic                            req1_valid,
    input  logic [WIDTH_OF_INPUT_DATA-1:0]  req1_data,
    output logic                            req1_ready,
    output logic                            out_valid,
    output logic [WIDTH_OF_OUTPUT_DATA-1:0] out_data,
    output logic                            out_source,
`ifdef SIGN_EXT_ARB_COUNT_EN
    output logic [15:0]                     grant_count0,
    output logic [15:0]                     grant_count1,
`endif
    input  logic                            out_ready
);

    localparam int unsigned W_IN  = WIDTH_OF_INPUT_DATA;
    localparam int unsigned W_OUT = WIDTH_OF_OUTPUT_DATA;
    localparam int unsigned EXT_W = W_OUT - W_IN;

    typedef struct packed {
        logic [W_OUT-1:0] data;
        logic             source;
    } result_t;

    logic      out_valid_q, out_valid_d;
    result_t   result_q, result_d;
    logic      prio_q, prio_d;

    logic      can_load_c;
    logic      grant0_c, grant1_c;
    logic      accept_c;
    logic      sel_c;
    logic [W_IN-1:0]  sel_data_c;
    logic [W_OUT-1:0] ext_data_c;

    // Output register accepts when empty or being drained this cycle.
    assign can_load_c = ~out_valid_q | out_ready;

    // Grant selection: a lone requester wins, otherwise the round-robin pointer decides.
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0_c = ~prio_q;
            grant1_c = prio_q;
        end else begin
            grant0_c = req0_valid;
            grant1_c = req1_valid;
        end
    end

    assign req0_ready = rst_n & can_load_c & grant0_c;
    assign req1_ready = rst_n & can_load_c & grant1_c;

    assign accept_c   = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign sel_c      = req1_ready;
    assign sel_data_c = sel_c ? req1_data : req0_data;

    // Single shared widening path.
    generate
        if (EXT_W == 0) begin : g_no_ext
            assign ext_data_c = sel_data_c;
        end else begin : g_ext
            assign ext_data_c = {{EXT_W{sel_data_c[W_IN-1]}}, sel_data_c};
        end
    endgenerate

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        prio_d      = prio_q;
        if (accept_c) begin
            out_valid_d     = 1'b1;
            result_d.data   = ext_data_c;
            result_d.source = sel_c;
            prio_d          = ~sel_c;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            prio_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            prio_q      <= prio_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = result_q.data;
    assign out_source = result_q.source;

`ifdef SIGN_EXT_ARB_COUNT_EN
    logic [15:0] grant_count0_q, grant_count0_d;
    logic [15:0] grant_count1_q, grant_count1_d;

    // Per-requester accept counters, wrapping naturally at 16 bits.
    always_comb begin
        grant_count0_d = grant_count0_q;
        grant_count1_d = grant_count1_q;
        if (req0_valid && req0_ready) begin
            grant_count0_d = grant_count0_q + 16'd1;
        end
        if (req1_valid && req1_ready) begin
            grant_count1_d = grant_count1_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_count0_q <= '0;
            grant_count1_q <= '0;
        end else begin
            grant_count0_q <= grant_count0_d;
            grant_count1_q <= grant_count1_d;
        end
    end

    assign grant_count0 = grant_count0_q;
    assign grant_count1 = grant_count1_q;
`endif

endmodule

// File: tb/tb_sign_extension_arbiter.sv
// Directed bench for sign_extension_arbiter: default 8->16 instance plus an 8->8 pass-through instance.
module tb_sign_extension_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, out_ready;
    logic [7:0]  req0_data, req1_data;
    logic        req0_ready, req1_ready, out_valid, out_source;
    logic [15:0] out_data;

    logic        n_req0_valid, n_req1_valid, n_out_ready;
    logic [7:0]  n_req0_data, n_req1_data;
    logic        n_req0_ready, n_req1_ready, n_out_valid, n_out_source;
    logic [7:0]  n_out_data;

`ifdef SIGN_EXT_ARB_COUNT_EN
    logic [15:0] grant_count0, grant_count1;
    logic [15:0] n_grant_count0, n_grant_count1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sign_extension_arbiter #(
        .WIDTH_OF_INPUT_DATA (8),
        .WIDTH_OF_OUTPUT_DATA(16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_source  (out_source),
`ifdef SIGN_EXT_ARB_COUNT_EN
        .grant_count0(grant_count0),
        .grant_count1(grant_count1),
`endif
        .out_ready   (out_ready)
    );

    sign_extension_arbiter #(
        .WIDTH_OF_INPUT_DATA (8),
        .WIDTH_OF_OUTPUT_DATA(8)
    ) dut_narrow (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (n_req0_valid),
        .req0_data   (n_req0_data),
        .req0_ready  (n_req0_ready),
        .req1_valid  (n_req1_valid),
        .req1_data   (n_req1_data),
        .req1_ready  (n_req1_ready),
        .out_valid   (n_out_valid),
        .out_data    (n_out_data),
        .out_source  (n_out_source),
`ifdef SIGN_EXT_ARB_COUNT_EN
        .grant_count0(n_grant_count0),
        .grant_count1(n_grant_count1),
`endif
        .out_ready   (n_out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [15:0] d, input logic s);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".data"}, 32'(out_data), 32'(d));
        chk({tag, ".src"}, 32'(out_source), 32'(s));
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_data = 8'h7F;
        req1_valid = 1'b1; req1_data = 8'h81;
        out_ready = 1'b1;
        n_req0_valid = 1'b0; n_req0_data = 8'h00;
        n_req1_valid = 1'b0; n_req1_data = 8'h00;
        n_out_ready = 1'b1;

        // Reset state and readys held low during reset
        step();
        step();
        chk_out("reset", 1'b0, 16'h0000, 1'b0);
        chk("reset.rdy0", 32'(req0_ready), 32'd0);
        chk("reset.rdy1", 32'(req1_ready), 32'd0);

        // Single requester with negative data; narrow instance pass-through
        rst_n = 1'b1;
        req1_valid = 1'b0;
        req0_data = 8'h80;
        n_req1_valid = 1'b1; n_req1_data = 8'hA5;
        #1;
        chk("single.rdy0", 32'(req0_ready), 32'd1);
        chk("single.rdy1", 32'(req1_ready), 32'd0);
        step();
        chk_out("single", 1'b1, 16'hFF80, 1'b0);
        chk("narrow.data", 32'(n_out_data), 32'hA5);
        chk("narrow.src", 32'(n_out_source), 32'd1);
        chk("narrow.valid", 32'(n_out_valid), 32'd1);
        n_req1_valid = 1'b0;
        req0_valid = 1'b0;
        step();
        chk("drain.valid", 32'(out_valid), 32'd0);

        // Round-robin alternation from a fresh reset, full throughput
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_data = 8'h7F;
        req1_valid = 1'b1; req1_data = 8'h81;
        out_ready = 1'b1;
        step();
        chk_out("rr0", 1'b1, 16'h007F, 1'b0);
        step();
        chk_out("rr1", 1'b1, 16'hFF81, 1'b1);
        step();
        chk_out("rr2", 1'b1, 16'h007F, 1'b0);
        step();
        chk_out("rr3", 1'b1, 16'hFF81, 1'b1);

        // Output stall for 3 cycles
        out_ready = 1'b0;
        #1;
        chk("stall.rdy0", 32'(req0_ready), 32'd0);
        chk("stall.rdy1", 32'(req1_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("stall", 1'b1, 16'hFF81, 1'b1);
            chk("stall.rdy0c", 32'(req0_ready), 32'd0);
            chk("stall.rdy1c", 32'(req1_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("release.rdy0", 32'(req0_ready), 32'd1);
        chk("release.rdy1", 32'(req1_ready), 32'd0);
        step();
        chk_out("release", 1'b1, 16'h007F, 1'b0);

        // Drain with no new accept
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        chk("drain2.valid", 32'(out_valid), 32'd0);

        // Reset during a stall discards the held result and resets prio
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        step();
        chk_out("pre_stall", 1'b1, 16'hFF81, 1'b1);
        out_ready = 1'b0;
        step();
        chk_out("stall2", 1'b1, 16'hFF81, 1'b1);
        rst_n = 1'b0;
        step();
        chk_out("rst_stall", 1'b0, 16'h0000, 1'b0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_rst.rdy0", 32'(req0_ready), 32'd1);
        chk("post_rst.rdy1", 32'(req1_ready), 32'd0);
        step();
        chk_out("post_rst", 1'b1, 16'h007F, 1'b0);

`ifdef SIGN_EXT_ARB_COUNT_EN
        // Counter wrap: 65537 accepts from requester 1
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            step();
        end
        req1_valid = 1'b0;
        step();
        chk("cnt1", 32'(grant_count1), 32'd1);
        chk("cnt0", 32'(grant_count0), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sign_extension_arbiter.md
SIGN_EXTENSION_ARBITER -- requirements
Module: sign_extension_arbiter

Interface
REQ-001 The module SHALL have parameter WIDTH_OF_INPUT_DATA, default 8, meaning the width of each requester's signed sample.
REQ-002 The module SHALL have parameter WIDTH_OF_OUTPUT_DATA, default 16, meaning the width of the widened result; it SHALL be >= WIDTH_OF_INPUT_DATA.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: the reset, which is synchronous and active-low.
REQ-005 The module SHALL have ports req0_valid (input, 1), req0_data (input, WIDTH_OF_INPUT_DATA) and req0_ready (output, 1): requester 0's handshake.
REQ-006 The module SHALL have ports req1_valid (input, 1), req1_data (input, WIDTH_OF_INPUT_DATA) and req1_ready (output, 1): requester 1's handshake.
REQ-007 The module SHALL have ports out_valid (output, 1), out_data (output, WIDTH_OF_OUTPUT_DATA), out_source (output, 1: granted requester index) and out_ready (input, 1): the consumer handshake.

Function
REQ-008 A transfer SHALL occur on any interface in a cycle where its valid and ready are both 1.
REQ-009 The block SHALL share one sign-extension path: out_data = {(W_OUT-W_IN) copies of data[W_IN-1], data}; when W_OUT = W_IN, out_data = data.
REQ-010 The output register SHALL be able to load when it is empty (out_valid=0) or being drained in the same cycle (out_valid & out_ready).
REQ-011 At most one requester SHALL be granted per cycle; reqN_ready SHALL be 1 only for the granted requester, and only when the output register can load.
REQ-012 If only one requester is valid, that requester SHALL be granted.
REQ-013 If both requesters are valid, the one indicated by the round-robin pointer (prio) SHALL be granted.
REQ-014 After each accepted transfer from requester N, prio SHALL become 1-N; with no transfer, prio SHALL hold.
REQ-015 Latency SHALL be 1 cycle: data accepted at edge k SHALL appear on out_data/out_source with out_valid=1 after edge k.
REQ-016 Full throughput SHALL be sustained: with out_ready held at 1, one result per cycle with no bubbles.
REQ-017 While out_valid=1 and out_ready=0 (output stall), out_data and out_source SHALL hold stable, both reqN_ready SHALL be 0, and prio SHALL not change.
REQ-018 If a drain and a new accept occur in the same cycle, out_valid SHALL stay 1 and the register SHALL take the new data.
REQ-019 If a drain occurs with no new accept, out_valid SHALL fall to 0 after that edge.
REQ-020 reqN_ready SHALL be combinationally derived from the valids, prio, out_valid and out_ready, and SHALL not depend on reqN_data.

Reset
REQ-021 When rst_n=0 at a rising edge, the block SHALL set out_valid=0, out_data=0, out_source=0 and prio=0 (requester 0 favoured first).
REQ-022 While rst_n=0, req0_ready and req1_ready SHALL be 0.
REQ-023 A reset asserted mid-stall SHALL discard the held result; no transfer SHALL be reported for that cycle.

Configuration
REQ-024 With macro SIGN_EXT_ARB_COUNT_EN defined, the block SHALL add outputs grant_count0 and grant_count1 (16 bits each), counting accepted transfers per requester, wrapping 0xFFFF->0x0000 and cleared by reset.
REQ-025 Without SIGN_EXT_ARB_COUNT_EN, those ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-026 Reset, then single requester: req0_data=0x80 valid, out_ready=1 -> next cycle out_data=0xFF80, out_source=0, out_valid=1.
REQ-027 Both requesters valid every cycle (req0=0x7F, req1=0x81), out_ready=1 -> outputs alternate: 0x007F src0, 0xFF81 src1, 0x007F src0 ...
REQ-028 Output stall: result 0xFF81 pending, out_ready=0 for 3 cycles -> out_data held, both readys 0; on release the next grant goes to the requester not last served.
REQ-029 Reset asserted during a stall -> out_valid=0 and prio=0 after the edge; the first grant after reset goes to requester 0 when both are valid.
REQ-030 With SIGN_EXT_ARB_COUNT_EN: 65537 accepts from req1 -> grant_count1=1, grant_count0=0.
REQ-031 With WIDTH_OF_INPUT_DATA=WIDTH_OF_OUTPUT_DATA=8: req1_data=0xA5 -> out_data=0xA5, out_source=1.
